// File: rtl/sm4_key_expand_if.sv
// Key-request / round-key bus between a key source and the SM4 key schedule.
// Key request: KEY_i and DEC_i are captured on any rising edge where KEY_VALID_i is high
// and the schedule is idle or done. Requests made while BUSY_o is high are dropped, not queued.
interface sm4_key_expand_if;
  logic [127:0]  KEY_i;
  logic          KEY_VALID_i;
  logic          DEC_i;
  logic [1023:0] RK_o;
  logic          RK_VALID_o;
  logic          RK_DONE_o;
  logic          BUSY_o;
  logic [1:0]    STATE_o;

  modport master (
    output KEY_i, KEY_VALID_i, DEC_i,
    input  RK_o, RK_VALID_o, RK_DONE_o, BUSY_o, STATE_o
  );

  modport slave (
    input  KEY_i, KEY_VALID_i, DEC_i,
    output RK_o, RK_VALID_o, RK_DONE_o, BUSY_o, STATE_o
  );
endinterface

// File: rtl/sm4_key_expand.sv
// Iterative SM4 key schedule: one round key per clock. The full 32-key set is
// committed to the round-key bus in a single edge, in encrypt or decrypt order.
module sbox_32b (
  input  logic [31:0] din,
  output logic [31:0] dout
);
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  // Entry 0 sits in the most significant byte of the table.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [10:0] idx;
    idx = 11'd2047 - {x, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  assign dout = {sb(din[31:24]), sb(din[23:16]), sb(din[15:8]), sb(din[7:0])};
endmodule

module sm4_key_expand (
  input  logic              CLK_i,
  input  logic              RST_N_i,
  sm4_key_expand_if.slave   bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  state_t        state;
  logic [4:0]    cnt;
  logic [127:0]  win;
  logic [1023:0] work;
  logic [1023:0] work_next;
  logic [1023:0] commit_val;
  logic [1023:0] rk_q;
  logic          dec_q;
  logic          rk_valid_q;
  logic          rk_done_q;
  logic          busy_q;

  logic [7:0]    ck_b0;
  logic [31:0]   ck;
  logic [31:0]   sbox_in;
  logic [31:0]   sbox_out;
  logic [31:0]   rk_new;

  // CK byte j = 28*i + 7*j, all modulo 256 by 8-bit truncation.
  always_comb begin
    ck_b0   = {3'b000, cnt} * 8'd28;
    ck      = {ck_b0, ck_b0 + 8'd7, ck_b0 + 8'd14, ck_b0 + 8'd21};
    sbox_in = win[95:64] ^ win[63:32] ^ win[31:0] ^ ck;
  end

  sbox_32b u_sbox (
    .din  (sbox_in),
    .dout (sbox_out)
  );

  always_comb begin
    rk_new = win[127:96] ^ sbox_out
           ^ {sbox_out[18:0], sbox_out[31:19]}
           ^ {sbox_out[8:0],  sbox_out[31:9]};
  end

  // work_next includes the key written this edge, so the commit sees all 32.
  always_comb begin
    work_next  = work;
    commit_val = '0;
    for (int s = 0; s < 32; s++) begin
      if (cnt == 5'(s)) work_next[1023-32*s -: 32] = rk_new;
    end
    for (int s = 0; s < 32; s++) begin
      commit_val[1023-32*s -: 32] = dec_q ? work_next[32*s+31 -: 32]
                                          : work_next[1023-32*s -: 32];
    end
  end

  always_ff @(posedge CLK_i or negedge RST_N_i) begin
    if (!RST_N_i) begin
      state      <= IDLE;
      cnt        <= '0;
      win        <= '0;
      work       <= '0;
      rk_q       <= '0;
      dec_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rk_done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.KEY_VALID_i) begin
            win    <= bus.KEY_i ^ FK;
            dec_q  <= bus.DEC_i;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          win  <= {win[95:0], rk_new};
          work <= work_next;
          if (cnt == 5'd31) begin
            rk_q       <= commit_val;
            rk_valid_q <= 1'b1;
            rk_done_q  <= 1'b1;
            busy_q     <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.RK_o       = rk_q;
  assign bus.RK_VALID_o = rk_valid_q;
  assign bus.RK_DONE_o  = rk_done_q;
  assign bus.BUSY_o     = busy_q;
  assign bus.STATE_o    = state;
endmodule

// File: doc/sm4_key_expand.md
# sm4_key_expand

Iterative SM4 key schedule that sits directly upstream of the 32-stage round pipeline and drives its 1024-bit round-key bus. It accepts a 128-bit master key, computes one round key per clock over 32 cycles, and commits all 32 keys to the output bus atomically, in encrypt or decrypt order. The output bus stays stable between commits, so data already in the round pipeline is never corrupted by a key change mid-flight.

## Interface
- No parameters. FK and CK constants are fixed by the SM4 standard.
- CLK_i  in  1  clock; all state updates on the rising edge.
- RST_N_i  in  1  reset, asynchronous, active-low.
- KEY_i  in  128  master key. MK0 = KEY_i[127:96], MK3 = KEY_i[31:0].
- KEY_VALID_i  in  1  start request; sampled only in IDLE or DONE.
- DEC_i  in  1  key order: 0 = encrypt, 1 = decrypt. Latched together with KEY_i.
- RK_o  out  1024  round-key bus. The slot at bits [1023:992] feeds pipeline stage 0; the slot at bits [31:0] feeds stage 31.
- RK_VALID_o  out  1  level; high while RK_o holds a completed key set.
- RK_DONE_o  out  1  one-cycle pulse on each commit.
- BUSY_o  out  1  high while in RUN.

## Operation
- **State machine.** States are IDLE, RUN and DONE.
  - IDLE to RUN when KEY_VALID_i = 1.
  - RUN to DONE after the 32nd round.
  - DONE to RUN when KEY_VALID_i = 1; otherwise DONE holds.
- **Accept edge** (KEY_VALID_i = 1 while in IDLE or DONE):
  - K0..K3 ← MK0..MK3 XOR FK0..FK3, with FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC.
  - Latch DEC_i.
  - Clear the 5-bit round counter.
- **Round i** (i = 0..31, one per cycle in RUN):
  - rk_i = K_i ^ L'(S(K_{i+1} ^ K_{i+2} ^ K_{i+3} ^ CK_i)).
  - S is the existing sbox_32b instance (four byte S-boxes).
  - L'(B) = B ^ (B<<<13) ^ (B<<<23).
  - CK_i byte j (j = 0 is the MSB) = (28·i + 7·j) mod 256. Generate it combinationally from the counter; no ROM.
  - Keep a sliding 4-word window (128 flops). rk_i is written into a 1024-bit working register at slot i.
- **Commit** (the edge that writes rk_31):
  - Encrypt: RK_o slot for stage s ← rk_s.
  - Decrypt: RK_o slot for stage s ← rk_{31-s}.
  - Set RK_VALID_o = 1 and pulse RK_DONE_o.
- RK_o is written only at the commit edge; the working register is private.
- KEY_VALID_i is ignored in RUN. No queueing; the request is lost.
- All arithmetic is 32-bit XOR and rotate. The counter runs 0..31 with no wrap while in RUN.

## Timing
- **Reset values.** RST_N_i low asynchronously forces:
  - state = IDLE, counter = 0;
  - RK_o = 0, RK_VALID_o = 0, RK_DONE_o = 0, BUSY_o = 0;
  - working register and window cleared.
- **Reset mid-RUN** aborts the expansion. Nothing is committed, and RK_VALID_o falls even if a previous set was valid.
- **Latency.** With the accept at edge N:
  - BUSY_o is high from after edge N through edge N+32.
  - rk_i is written at edge N+1+i.
  - Commit is at edge N+32.
  - RK_DONE_o is high for exactly the cycle after edge N+32, and BUSY_o is low in that cycle.
- **RK_VALID_o during re-key.**
  - It stays high during a re-key started from DONE, because the old keys remain on RK_o until the new commit.
  - It is 0 before the first commit.
- **Back-to-back.** KEY_VALID_i held high in DONE restarts on the cycle after the pulse. Throughput is one key set per 33 cycles.
- **Simultaneous events.** A KEY_VALID_i arriving in the same cycle that RK_DONE_o is high is accepted. DONE and the pulse coexist in that cycle.

## Test plan
- **Standard vector, encrypt.**
  - Stimulus: KEY_i = 0123456789ABCDEFFEDCBA9876543210, DEC_i = 0, one-cycle KEY_VALID_i.
  - Required response: after 32 cycles, RK_o[1023:992] = F12186F9, next slot = 41662B61, RK_o[31:0] = 9124A012; RK_DONE_o pulses once; RK_VALID_o = 1.
- **Same key, decrypt.**
  - Stimulus: as above with DEC_i = 1.
  - Required response: RK_o[1023:992] = 9124A012 and RK_o[31:0] = F12186F9.
  - Chained with the round pipeline, decrypting ciphertext 681EDF34D206965E86B3E94F536E4246 returns the plaintext 0123456789ABCDEFFEDCBA9876543210.
- **Stability during re-key.**
  - Stimulus: after the encrypt commit, start a new key.
  - Required response: RK_o is bit-identical to the old set for all 32 RUN cycles, then changes in a single edge; RK_VALID_o never drops.
- **Request during RUN ignored.**
  - Stimulus: pulse KEY_VALID_i with a different key at RUN cycle 10.
  - Required response: the committed keys match the first key; BUSY_o falls exactly 32 edges after the original accept.
- **Reset mid-operation.**
  - Stimulus: assert RST_N_i at RUN cycle 15 after a prior valid commit.
  - Required response: all outputs go to 0 immediately. A fresh request afterwards produces the correct set after 32 cycles.
- **Back-to-back.**
  - Stimulus: hold KEY_VALID_i high with a constant key.
  - Required response: RK_DONE_o pulses every 33 cycles and RK_o is identical on every commit.
